// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA pattern scheduler.
// Optional fade feature is enabled by defining VGA_PATTERN_FADE_EN.
package vga_sched_pkg;

  // Scheduler states; the fade states are only reachable with fading enabled.
  typedef enum logic [1:0] {
    S_SHOW     = 2'd0,
    S_PEND     = 2'd1,
    S_FADE_OUT = 2'd2,
    S_FADE_IN  = 2'd3
  } sched_state_e;

  // Pattern mode codes.
  localparam logic [2:0] MODE_XBARS   = 3'd0;
  localparam logic [2:0] MODE_YBARS   = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_GRAD    = 3'd3;
  localparam logic [2:0] MODE_WHITE   = 3'd4;

  // Depth of the switch synchronisers.
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern generator: mode + pixel coordinates -> RGB.
// Unused mode codes produce black.
module vga_pattern_gen
  import vga_sched_pkg::*;
(
  input  logic [2:0] mode,
  input  logic [9:0] coord_x,
  input  logic [9:0] coord_y,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  // Coordinate bits that no pattern looks at.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{coord_x[1:0], coord_y[9], coord_y[0]};

  // Pick the pattern for the current mode.
  always_comb begin
    red   = 8'h00;
    green = 8'h00;
    blue  = 8'h00;
    case (mode)
      MODE_XBARS: begin
        red   = {8{~coord_x[7]}};
        green = {8{~coord_x[6]}};
        blue  = {8{~coord_x[5]}};
      end
      MODE_YBARS: begin
        red   = {8{~coord_y[7]}};
        green = {8{~coord_y[6]}};
        blue  = {8{~coord_y[5]}};
      end
      MODE_CHECKER: begin
        red   = {8{coord_x[5] ^ coord_y[5]}};
        green = {8{coord_x[5] ^ coord_y[5]}};
        blue  = {8{coord_x[5] ^ coord_y[5]}};
      end
      MODE_GRAD: begin
        red   = coord_x[9:2];
        green = coord_y[8:1];
        blue  = 8'h00;
      end
      MODE_WHITE: begin
        red   = 8'hFF;
        green = 8'hFF;
        blue  = 8'hFF;
      end
      default: begin
        red   = 8'h00;
        green = 8'h00;
        blue  = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Selects the VGA test pattern and defers mode changes to frame boundaries.
// Manual selection from switches, or timed auto-cycling through modes.
// Define VGA_PATTERN_FADE_EN to fade out/in across a mode change.
//
// Handshake note: there is no valid/ready pair here; the only qualifier is
// 'enable', a pixel-rate strobe. Every register except the switch
// synchronisers holds its value while enable=0 and advances when enable=1.
module vga_pattern_scheduler
  import vga_sched_pkg::*;
#(
  parameter int NUM_MODES    = 5,
  parameter int DWELL_FRAMES = 60,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [9:0]             iCoord_X,
  input  logic [9:0]             iCoord_Y,
  input  logic [2:0]             iMode_req,
  input  logic                   iAuto,
  output logic [7:0]             oRed,
  output logic [7:0]             oGreen,
  output logic [7:0]             oBlue,
  output logic [2:0]             oMode,
  output logic                   oPending,
  output logic [FRAME_CNT_W-1:0] oFrame_count,
  output logic [1:0]             oState
);

  localparam int              DW          = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW-1:0]   DWELL_LAST  = DW'(DWELL_FRAMES - 1);
  localparam logic [3:0]      NUM_MODES_W = 4'(NUM_MODES);
  localparam logic [2:0]      LAST_MODE   = 3'(NUM_MODES - 1);

  logic [SYNC_DEPTH-1:0][2:0] req_sync;
  logic [SYNC_DEPTH-1:0]      auto_sync;
  logic [2:0]                 req_s;
  logic                       auto_s;

  sched_state_e   state, state_d;
  logic [2:0]     pend_mode, pend_d, mode_d, next_mode;
  logic [DW-1:0]  dwell, dwell_d;
  logic [9:0]     prev_y;
  logic           fb, req_ok, dwell_done, swap;
  logic [7:0]     pat_r, pat_g, pat_b;
`ifdef VGA_PATTERN_FADE_EN
  logic [1:0]     level, level_d;
`endif

  // Two-flop synchronisers for the raw switches, clocked every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_sync  <= '0;
      auto_sync <= '0;
    end else begin
      req_sync[0]  <= iMode_req;
      auto_sync[0] <= iAuto;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        req_sync[i]  <= req_sync[i-1];
        auto_sync[i] <= auto_sync[i-1];
      end
    end
  end

  assign req_s      = req_sync[SYNC_DEPTH-1];
  assign auto_s     = auto_sync[SYNC_DEPTH-1];
  assign fb         = enable && (iCoord_Y == 10'd0) && (prev_y != 10'd0);
  // A request is acted on only if it names a real mode different from the shown one.
  assign req_ok     = ({1'b0, req_s} < NUM_MODES_W) && (req_s != oMode);
  assign dwell_done = auto_s && (dwell == DWELL_LAST);
  assign next_mode  = (oMode == LAST_MODE) ? 3'd0 : oMode + 3'd1;
  assign oPending   = (state != S_SHOW);
  assign oState     = state;

  // Next-state logic; a manual request takes priority over auto expiry.
  always_comb begin
    state_d = state;
    pend_d  = pend_mode;
    mode_d  = oMode;
    swap    = 1'b0;
`ifdef VGA_PATTERN_FADE_EN
    level_d = level;
`endif
    case (state)
      S_SHOW: begin
        if (req_ok) begin
          pend_d  = req_s;
          state_d = S_PEND;
        end else if (fb && dwell_done) begin
          pend_d  = next_mode;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (req_ok) pend_d = req_s;
        if (fb) begin
`ifdef VGA_PATTERN_FADE_EN
          state_d = S_FADE_OUT;
          level_d = 2'd0;
`else
          mode_d  = pend_d;
          swap    = 1'b1;
          state_d = S_SHOW;
`endif
        end
      end
`ifdef VGA_PATTERN_FADE_EN
      S_FADE_OUT: begin
        if (req_ok) pend_d = req_s;
        if (fb) begin
          if (level == 2'd3) begin
            mode_d  = pend_d;
            swap    = 1'b1;
            state_d = S_FADE_IN;
          end else begin
            level_d = level + 2'd1;
          end
        end
      end
      S_FADE_IN: begin
        if (req_ok) pend_d = req_s;
        if (fb) begin
          if (level != 2'd0) level_d = level - 2'd1;
          if (level <= 2'd1) state_d = S_SHOW;
        end
      end
`endif
      default: state_d = S_SHOW;
    endcase

    dwell_d = dwell;
    if (!auto_s || swap)              dwell_d = '0;
    else if (fb && (state == S_SHOW)) dwell_d = dwell + DW'(1);
  end

  // Scheduler registers, advanced on the pixel strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_SHOW;
      pend_mode    <= '0;
      oMode        <= '0;
      dwell        <= '0;
      prev_y       <= '0;
      oFrame_count <= '0;
`ifdef VGA_PATTERN_FADE_EN
      level        <= '0;
`endif
    end else if (enable) begin
      state     <= state_d;
      pend_mode <= pend_d;
      oMode     <= mode_d;
      dwell     <= dwell_d;
      prev_y    <= iCoord_Y;
      if (fb) oFrame_count <= oFrame_count + FRAME_CNT_W'(1);
`ifdef VGA_PATTERN_FADE_EN
      level     <= level_d;
`endif
    end
  end

  vga_pattern_gen u_gen (
    .mode    (oMode),
    .coord_x (iCoord_X),
    .coord_y (iCoord_Y),
    .red     (pat_r),
    .green   (pat_g),
    .blue    (pat_b)
  );

  // Colour registers: one enable of latency from coordinates to colour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else if (enable) begin
`ifdef VGA_PATTERN_FADE_EN
      oRed   <= pat_r >> level;
      oGreen <= pat_g >> level;
      oBlue  <= pat_b >> level;
`else
      oRed   <= pat_r;
      oGreen <= pat_g;
      oBlue  <= pat_b;
`endif
    end
  end

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Self-checking bench for vga_pattern_scheduler (short synthetic frames).
module tb_vga_pattern_scheduler;

  localparam int NUM_MODES = 5;
  localparam int DWELL     = 3;
  localparam int FCW       = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset, enable, auto_sw;
  logic [9:0] cx, cy;
  logic [2:0] req_sw;
  logic [7:0] o_r, o_g, o_b;
  logic [2:0] o_mode;
  logic o_pend;
  logic [FCW-1:0] o_frames;
  logic [1:0] dbg_state;

  always #10 clock = ~clock;

  vga_pattern_scheduler #(
    .NUM_MODES(NUM_MODES), .DWELL_FRAMES(DWELL), .FRAME_CNT_W(FCW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .iCoord_X(cx), .iCoord_Y(cy), .iMode_req(req_sw), .iAuto(auto_sw),
    .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oMode(o_mode),
    .oPending(o_pend), .oFrame_count(o_frames), .oState(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Settled switch values as the scheduler sees them.
  int cur_req, cur_auto;
  // Displayed mode, queued change, frames shown under auto, frames seen.
  int m_mode, m_target, m_dwell, m_frames, m_prev_y;
  bit m_pend;
  logic [23:0] m_rgb;

  function automatic logic [23:0] ref_rgb(input int mode, input int x, input int y);
    int r, g, b;
    r = 0; g = 0; b = 0;
    case (mode)
      0: begin r = ((x/128)%2) ? 0 : 255; g = ((x/64)%2) ? 0 : 255; b = ((x/32)%2) ? 0 : 255; end
      1: begin r = ((y/128)%2) ? 0 : 255; g = ((y/64)%2) ? 0 : 255; b = ((y/32)%2) ? 0 : 255; end
      2: begin r = (((x/32) + (y/32)) % 2) ? 255 : 0; g = r; b = r; end
      3: begin r = (x/4) % 256; g = (y/2) % 256; b = 0; end
      4: begin r = 255; g = 255; b = 255; end
      default: begin r = 0; g = 0; b = 0; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_target = 0; m_pend = 0; m_dwell = 0; m_frames = 0; m_prev_y = 0;
    m_rgb = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int x, input int y);
    @(negedge clock);
    cx = 10'(x); cy = 10'(y); enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  // One pixel strobe, then advance the model and compare.
  task automatic pix(input int x, input int y);
    bit fb, was_show, swapped, valid;
    drive(x, y);
    fb       = (y == 0) && (m_prev_y != 0);
    m_rgb    = ref_rgb(m_mode, x, y);
    m_prev_y = y;
    was_show = !m_pend;
    swapped  = 0;
    valid    = (cur_req < NUM_MODES) && (cur_req != m_mode);
    if (fb) m_frames = (m_frames + 1) % (1 << FCW);
    if (!m_pend) begin
      if (valid) begin
        m_pend = 1; m_target = cur_req;
      end else if (fb && cur_auto != 0 && m_dwell == DWELL - 1) begin
        m_pend = 1; m_target = (m_mode + 1) % NUM_MODES;
      end
    end else begin
      if (valid) m_target = cur_req;
      if (fb) begin m_mode = m_target; m_pend = 0; swapped = 1; end
    end
    if (cur_auto == 0 || swapped) m_dwell = 0;
    else if (fb && was_show)      m_dwell++;
    check("rgb",     {8'h0, o_r, o_g, o_b}, {8'h0, m_rgb});
    check("mode",    32'(o_mode),   32'(m_mode));
    check("pending", 32'(o_pend),   32'(m_pend));
    check("frames",  32'(o_frames), 32'(m_frames));
  endtask

  // Change the switches with the strobe idle so the synchronisers settle.
  task automatic set_sw(input int r, input int a);
    req_sw = 3'(r); auto_sw = (a != 0);
    cur_req = r; cur_auto = a;
    repeat (4) @(negedge clock);
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) pix($urandom_range(0, 639), $urandom_range(1, 479));
    pix($urandom_range(0, 639), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"},    {8'h0, o_r, o_g, o_b}, 32'h0);
    check({tag, "_mode"},   32'(o_mode), 32'h0);
    check({tag, "_pend"},   32'(o_pend), 32'h0);
    check({tag, "_frames"}, 32'(o_frames), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    logic [7:0] fade_tbl [8];
    int         fmode_tbl [8];

    reset = 1'b1; enable = 1'b0; cx = '0; cy = '0; req_sw = '0; auto_sw = 1'b0;
    cur_req = 0; cur_auto = 0;
    model_reset();
    #15;
    check_reset_outputs("reset");
    check("reset_state", 32'(dbg_state), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    set_sw(0, 0);

    // Mode 0 vertical bars across X on a fixed line.
    for (int x = 0; x < 256; x++) pix(x, 10);

`ifndef VGA_PATTERN_FADE_EN
    // Request mode 2 mid-frame; change lands at the next frame start.
    set_sw(2, 0);
    pix(50, 200);
    pix(60, 479);
    check("mode_held_before_fb", 32'(o_mode), 32'h0);
    pix(32, 0);
    check("mode2_after_fb", 32'(o_mode), 32'h2);
    pix(32, 0);
    pix(100, 40);

    // Out-of-range request is ignored.
    set_sw(7, 0);
    run_frame(3);
    check("req7_no_pending", 32'(o_pend), 32'h0);
    check("req7_mode_kept",  32'(o_mode), 32'h2);

    // Random manual requests, sometimes changed again mid-frame.
    for (int it = 0; it < 30; it++) begin
      set_sw($urandom_range(0, 7), 0);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        pix($urandom_range(0, 639), $urandom_range(1, 479));
      if ($urandom_range(0, 1) == 1) begin
        set_sw($urandom_range(0, 7), 0);
        pix($urandom_range(0, 639), $urandom_range(1, 479));
      end
      pix($urandom_range(0, 639), 0);
      if ($urandom_range(0, 3) == 0) pix($urandom_range(0, 639), 0);
    end
    run_frame(2);
    run_frame(2);

    // Auto-cycle with the switches following the displayed mode.
    set_sw(m_mode, 1);
    for (int f = 0; f < 26; f++) begin
      run_frame(2);
      if (m_pend && cur_req != m_target) set_sw(m_target, 1);
    end

    // Manual request on the very frame auto would advance out of mode 1.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      pix($urandom_range(0, 639), $urandom_range(1, 479));
      if (m_mode == 1 && !m_pend && m_dwell == DWELL - 1) begin
        found = 1;
        set_sw(3, 1);
        pix($urandom_range(0, 639), 0);
        check("same_cycle_pending", 32'(o_pend), 32'h1);
        run_frame(2);
        check("same_cycle_manual_wins", 32'(o_mode), 32'h3);
      end else begin
        pix($urandom_range(0, 639), 0);
        if (m_pend && cur_req != m_target) set_sw(m_target, 1);
      end
    end
    check("auto_reached_mode1", 32'(found), 32'h1);
    set_sw(m_mode, 0);
    run_frame(2);

    // Reset while a change is queued discards it.
    set_sw((m_mode + 2) % NUM_MODES, 0);
    pix(5, 50);
    check("pending_before_reset", 32'(o_pend), 32'h1);
    #3 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    set_sw(0, 0);
    run_frame(2);
    run_frame(1);
`else
    // Fade: get to white first.
    set_sw(4, 0);
    for (int f = 0; f < 9; f++) begin drive(7, 300); drive(7, 0); end
    drive(0, 10);
    check("fade_in_white_mode", 32'(o_mode), 32'h4);
    check("fade_in_white_pend", 32'(o_pend), 32'h0);
    check("fade_in_white_rgb",  {8'h0, o_r, o_g, o_b}, 32'hFFFFFF);

    // White -> mode 0; sample (0,10) after each frame start.
    fade_tbl  = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    fmode_tbl = '{4, 4, 4, 4, 0, 0, 0, 0};
    set_sw(0, 0);
    drive(0, 10);
    check("fade_pending", 32'(o_pend), 32'h1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0);
      drive(0, 10);
      check($sformatf("fade_rgb_%0d", k), {8'h0, o_r, o_g, o_b},
            {8'h0, fade_tbl[k], fade_tbl[k], fade_tbl[k]});
      check($sformatf("fade_mode_%0d", k), 32'(o_mode), 32'(fmode_tbl[k]));
      check($sformatf("fade_pend_%0d", k), 32'(o_pend), (k == 7) ? 32'h0 : 32'h1);
    end

    // Reset in the middle of a fade.
    set_sw(4, 0);
    drive(0, 10); drive(0, 0); drive(0, 10); drive(0, 0); drive(0, 10);
    check("fade_mid_pend", 32'(o_pend), 32'h1);
    #3 reset = 1'b1;
    #1 check_reset_outputs("fade_reset");
    @(negedge clock);
    reset = 1'b0;
    set_sw(0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
